// File: rtl/e_mdu_if.sv
// e_mdu_if -- operand/result bundle between the E-stage and the multiply/divide unit.
//
// Signals:
//   MDUOp   [3:0]  operation code (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                  5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none)
//   A, B    [31:0] forwarded rs / rt operands
//   start          combinational: MDUOp is mult/multu/div/divu
//   busy           registered: an operation is in flight
//   HI, LO  [31:0] architectural HI/LO registers
//   MDUOut  [31:0] combinational mfhi/mflo read data (0 otherwise)
//
// Handshake: there is no valid/ready pair. A start op is accepted at the
// rising edge where it is presented only if busy is 0 at that edge; the
// hazard unit keeps any MD-class instruction in D while (start | busy), so
// a start op or mthi/mtlo seen while busy = 1 is dropped by the unit. The
// result becomes visible on HI/LO in the same edge at which busy falls.

interface e_mdu_if;
   logic [3:0]  MDUOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        start;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDUOut;

   // master: E-stage / hazard side
   modport master (
      output MDUOp, A, B,
      input  start, busy, HI, LO, MDUOut
   );

   // slave: the multiply/divide unit
   modport slave (
      input  MDUOp, A, B,
      output start, busy, HI, LO, MDUOut
   );
endinterface

// File: rtl/e_mdu.sv
// e_mdu -- execute-stage multiply/divide unit holding the HI/LO registers.
//
// The result of mult/multu/div/divu is computed combinationally when the op
// is captured and parked in pend_hi/pend_lo; a down-counter then models the
// multi-cycle latency and commits pend_* to HI/LO when it expires.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   mdu    e_mdu_if.slave (MDUOp, A, B in; start, busy, HI, LO, MDUOut out)
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (1..15, cnt is 4 bits)
//   DIV_CYCLES   busy cycles for div/divu   (1..15, cnt is 4 bits)

module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic   clk,
   input  logic   reset,
   e_mdu_if.slave mdu
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   logic [31:0] hi_q, lo_q;
   logic [31:0] pend_hi_q, pend_lo_q;
   logic [3:0]  cnt_q;
   logic        busy_q;

   logic [31:0] res_hi_d, res_lo_d;
   logic        is_start, is_mul;

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic signed [31:0] sa, sb, quo_s, rem_s;
   logic        [31:0] quo_u, rem_u;

   assign is_start = (mdu.MDUOp == OP_MULT) || (mdu.MDUOp == OP_MULTU) ||
                     (mdu.MDUOp == OP_DIV)  || (mdu.MDUOp == OP_DIVU);
   assign is_mul   = (mdu.MDUOp == OP_MULT) || (mdu.MDUOp == OP_MULTU);

   // Operands are extended explicitly so the 64-bit products never depend
   // on context-width rules.
   assign prod_s = $signed({{32{mdu.A[31]}}, mdu.A}) * $signed({{32{mdu.B[31]}}, mdu.B});
   assign prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};

   // Signed '/' truncates toward zero and '%' takes the dividend's sign,
   // matching MIPS div; the B = 0 and overflow cases are overridden below.
   assign sa    = $signed(mdu.A);
   assign sb    = $signed(mdu.B);
   assign quo_s = sa / sb;
   assign rem_s = sa % sb;
   assign quo_u = mdu.A / mdu.B;
   assign rem_u = mdu.A % mdu.B;

   always_comb begin
      res_hi_d = hi_q;
      res_lo_d = lo_q;
      unique case (mdu.MDUOp)
         OP_MULT: begin
            res_hi_d = prod_s[63:32];
            res_lo_d = prod_s[31:0];
         end
         OP_MULTU: begin
            res_hi_d = prod_u[63:32];
            res_lo_d = prod_u[31:0];
         end
         OP_DIV: begin
            if (mdu.B == 32'd0) begin
               // Divide by zero: commit the current HI/LO back unchanged.
               res_hi_d = hi_q;
               res_lo_d = lo_q;
            end else if ((mdu.A == 32'h8000_0000) && (mdu.B == 32'hFFFF_FFFF)) begin
               res_hi_d = 32'd0;
               res_lo_d = 32'h8000_0000;
            end else begin
               res_hi_d = rem_s;
               res_lo_d = quo_s;
            end
         end
         OP_DIVU: begin
            if (mdu.B == 32'd0) begin
               res_hi_d = hi_q;
               res_lo_d = lo_q;
            end else begin
               res_hi_d = rem_u;
               res_lo_d = quo_u;
            end
         end
         default: begin
            res_hi_d = hi_q;
            res_lo_d = lo_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         cnt_q     <= 4'd0;
         busy_q    <= 1'b0;
      end else if (busy_q) begin
         // Everything presented while busy (start, mthi, mtlo) is dropped.
         if (cnt_q == 4'd1) begin
            hi_q   <= pend_hi_q;
            lo_q   <= pend_lo_q;
            busy_q <= 1'b0;
            cnt_q  <= 4'd0;
         end else begin
            cnt_q <= cnt_q - 4'd1;
         end
      end else if (is_start) begin
         pend_hi_q <= res_hi_d;
         pend_lo_q <= res_lo_d;
         cnt_q     <= is_mul ? MULT_CNT : DIV_CNT;
         busy_q    <= 1'b1;
      end else if (mdu.MDUOp == OP_MTHI) begin
         hi_q <= mdu.A;
      end else if (mdu.MDUOp == OP_MTLO) begin
         lo_q <= mdu.A;
      end
   end

   assign mdu.start  = is_start;
   assign mdu.busy   = busy_q;
   assign mdu.HI     = hi_q;
   assign mdu.LO     = lo_q;
   assign mdu.MDUOut = (mdu.MDUOp == OP_MFHI) ? hi_q :
                       (mdu.MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule
